// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Front end for the single-clock dual-address RAM. It takes independent
//   write and read requests over valid/ready handshakes and serialises them
//   onto the RAM's one write-or-read-per-clock control. It range-checks
//   addresses against DEPTH, returns read data two cycles after acceptance,
//   and keeps saturating counts of in-range writes and reads.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   wr_valid/ready       write request handshake; wr_ready is combinational
//   wr_addr, wr_data     write request payload
//   wr_err               pulse: accepted write was out of range and dropped
//   rd_valid/ready       read request handshake; rd_ready is combinational
//   rd_addr              read request address
//   rsp_valid/data/err   read response (pulse, no backpressure)
//   mem_*                registered RAM controls, and RAM read data in
//   wr_count, rd_count   saturating counts of in-range writes and reads
module ram_port_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 512,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [ADDR_W-1:0] mem_read_address,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count
);

  // One extra bit so that DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  logic              prio_q;  // 0: write wins a tie, 1: read wins a tie
  logic              wr_grant, rd_grant, wr_in, rd_in;
  logic              mem_write_q, wr_err_q;
  logic [ADDR_W-1:0] waddr_q, raddr_q;
  logic [DATA_W-1:0] wdata_q, rsp_data_q;
  logic [CNT_W-1:0]  wr_cnt_q, rd_cnt_q;
  logic [1:0]        vld_pipe_q, err_pipe_q;  // read tracking, index 1 is older
  logic              rsp_valid_q, rsp_err_q;

  always_comb begin
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    if (!rst) begin
      wr_grant = wr_valid && (!rd_valid || !prio_q);
      rd_grant = rd_valid && (!wr_valid ||  prio_q);
    end
    wr_in = ({1'b0, wr_addr} < LIMIT);
    rd_in = ({1'b0, rd_addr} < LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q      <= 1'b0;
      mem_write_q <= 1'b0;
      wr_err_q    <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      raddr_q     <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      vld_pipe_q  <= '0;
      err_pipe_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      // Any grant hands the tie-break to the other side.
      if (wr_grant)      prio_q <= 1'b1;
      else if (rd_grant) prio_q <= 1'b0;

      mem_write_q <= wr_grant && wr_in;
      wr_err_q    <= wr_grant && !wr_in;

      if (wr_grant && wr_in) begin
        waddr_q <= wr_addr;
        wdata_q <= wr_data;
        if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      end
      // Out-of-range reads leave the RAM read address untouched.
      if (rd_grant && rd_in) begin
        raddr_q <= rd_addr;
        if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      end

      vld_pipe_q <= {vld_pipe_q[0], rd_grant};
      err_pipe_q <= {err_pipe_q[0], rd_grant && !rd_in};

      // RAM read data is valid after T1; capture it at T2.
      rsp_valid_q <= vld_pipe_q[1];
      rsp_err_q   <= vld_pipe_q[1] && err_pipe_q[1];
      if (vld_pipe_q[1]) rsp_data_q <= err_pipe_q[1] ? '0 : mem_data_out;
    end
  end

  assign wr_ready          = wr_grant;
  assign rd_ready          = rd_grant;
  assign wr_err            = wr_err_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_data          = rsp_data_q;
  assign rsp_err           = rsp_err_q;
  assign mem_write         = mem_write_q;
  assign mem_write_address = waddr_q;
  assign mem_data_in       = wdata_q;
  assign mem_read_address  = raddr_q;
  assign wr_count          = wr_cnt_q;
  assign rd_count          = rd_cnt_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 512;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid, rd_valid;
  logic              wr_ready, rd_ready, wr_err;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rsp_valid, rsp_err;
  logic [DATA_W-1:0] rsp_data;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_write_address, mem_read_address;
  logic [DATA_W-1:0] mem_data_in, mem_data_out;
  logic [CNT_W-1:0]  wr_count, rd_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_write(mem_write), .mem_write_address(mem_write_address), .mem_data_in(mem_data_in),
    .mem_read_address(mem_read_address), .mem_data_out(mem_data_out),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  // Behavioural RAM: one write or one registered read per clock.
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ram_dout = '0;
  initial for (int i = 0; i < (1<<ADDR_W); i++) ram[i] = '0;
  always @(posedge clk) begin
    if (mem_write) ram[mem_write_address] <= mem_data_in;
    else           ram_dout <= ram[mem_read_address];
  end
  assign mem_data_out = ram_dout;

  // Stimulus drivers (no checking inside).
  task automatic apply_reset();
    @(negedge clk); rst = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk); wr_valid = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1 wr_valid = 1'b0;
  endtask

  // Issues one read and reports whether the response showed up exactly
  // two edges after acceptance, plus its payload.
  task automatic do_read(input logic [ADDR_W-1:0] a, output logic lat_ok,
                         output logic [DATA_W-1:0] d, output logic e);
    logic v1;
    @(negedge clk); rd_valid = 1'b1; rd_addr = a;
    @(posedge clk); #1 rd_valid = 1'b0;
    @(posedge clk); #1 v1 = rsp_valid;
    @(posedge clk); #1;
    lat_ok = !v1 && rsp_valid;
    d = rsp_data;
    e = rsp_err;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 1; rd_addr = 2; wr_data = 8'hFF;
    @(posedge clk); #1;
    n_assert++;
    if ({wr_ready, rd_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", {wr_ready, rd_ready}); end
    n_assert++;
    if ({wr_err, rsp_valid, rsp_err, mem_write, rsp_data, mem_write_address, mem_data_in,
         mem_read_address, wr_count, rd_count} !== '0) begin
      n_fail++; $display("FAIL reset_outputs some output nonzero: we=%b wa=%0d rc=%0d wc=%0d", mem_write, mem_write_address, rd_count, wr_count);
    end
    @(negedge clk); wr_valid = 1'b0; rd_valid = 1'b0; rst = 1'b0;
  endtask

  task automatic test_basic();
    logic ok, e; logic [DATA_W-1:0] d;
    @(negedge clk); wr_valid = 1'b1; wr_addr = 5; wr_data = 8'hA7; #1;
    n_assert++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL basic_wr_ready got %b want 1", wr_ready); end
    @(posedge clk); #1 wr_valid = 1'b0;
    n_assert++;
    if ({mem_write, mem_write_address, mem_data_in} !== {1'b1, 10'd5, 8'hA7}) begin
      n_fail++; $display("FAIL basic_issue got we=%b a=%0d d=%h want 1/5/a7", mem_write, mem_write_address, mem_data_in);
    end
    do_read(5, ok, d, e);
    n_assert++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_latency got %b want 1", ok); end
    n_assert++;
    if ({d, e} !== {8'hA7, 1'b0}) begin n_fail++; $display("FAIL basic_rsp got %h/%b want a7/0", d, e); end
    n_assert++;
    if ({wr_count, rd_count} !== {4'd1, 4'd1}) begin n_fail++; $display("FAIL basic_counts got %0d/%0d want 1/1", wr_count, rd_count); end
    @(posedge clk); #1;
    n_assert++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_rsp_pulse got %b want 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_w;
    int wi;
    exp_w = 4'b0101;  // bit i: write granted in cycle i
    wi = 0;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 10'(10 + wi); wr_data = 8'(1 + wi); rd_addr = 20; #1;
      n_assert++;
      if ({wr_ready, rd_ready} !== {exp_w[i], !exp_w[i]}) begin
        n_fail++; $display("FAIL rr_grant_%0d got w%b r%b want w%b", i, wr_ready, rd_ready, exp_w[i]);
      end
      if (exp_w[i]) wi++;
      @(posedge clk); #1;
      n_assert++;
      if (mem_write !== exp_w[i]) begin n_fail++; $display("FAIL rr_mem_write_%0d got %b want %b", i, mem_write, exp_w[i]); end
    end
    @(negedge clk); wr_valid = 1'b0; rd_valid = 1'b0;
    n_assert++;
    if ({wr_count, rd_count, ram[10], ram[11]} !== {4'd2, 4'd2, 8'd1, 8'd2}) begin
      n_fail++; $display("FAIL rr_result got wc%0d rc%0d m10=%0d m11=%0d want 2/2/1/2", wr_count, rd_count, ram[10], ram[11]);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_range();
    logic ok, e; logic [DATA_W-1:0] d; logic [CNT_W-1:0] wc0, rc0;
    wc0 = wr_count;
    @(negedge clk); wr_valid = 1'b1; wr_addr = 600; wr_data = 8'h55; #1;
    n_assert++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL oor_wr_ready got %b want 1", wr_ready); end
    @(posedge clk); #1 wr_valid = 1'b0;
    n_assert++;
    if ({mem_write, wr_err, wr_count} !== {1'b0, 1'b1, wc0}) begin
      n_fail++; $display("FAIL oor_wr_issue got we%b err%b wc%0d want 0/1/%0d", mem_write, wr_err, wr_count, wc0);
    end
    @(posedge clk); #1;
    n_assert++;
    if (wr_err !== 1'b0) begin n_fail++; $display("FAIL oor_wr_err_pulse got %b want 0", wr_err); end
    do_write(511, 8'h3C);
    do_read(511, ok, d, e);
    n_assert++;
    if ({ok, d, e} !== {1'b1, 8'h3C, 1'b0}) begin n_fail++; $display("FAIL edge_511 got lat%b %h/%b want 1 3c/0", ok, d, e); end
    rc0 = rd_count;
    do_read(512, ok, d, e);
    n_assert++;
    if ({ok, d, e} !== {1'b1, 8'h00, 1'b1}) begin n_fail++; $display("FAIL oor_rd got lat%b %h/%b want 1 00/1", ok, d, e); end
    n_assert++;
    if ({mem_read_address, rd_count} !== {10'd511, rc0}) begin
      n_fail++; $display("FAIL oor_rd_hold got ra%0d rc%0d want 511/%0d", mem_read_address, rd_count, rc0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) do_write(10'(i), 8'(8'h10 + i));
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); rd_valid = (i < 4); rd_addr = 10'(i);
      @(posedge clk); #1;
      n_assert++;
      if (i >= 2 && i <= 5) begin
        if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 8'(8'h10 + i - 2)}) begin
          n_fail++; $display("FAIL b2b_rsp_%0d got v%b e%b %h want 1/0/%h", i, rsp_valid, rsp_err, rsp_data, 8'(8'h10 + i - 2));
        end
      end else if (rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL b2b_idle_%0d got %b want 0", i, rsp_valid);
      end
    end
    @(negedge clk); rd_valid = 1'b0;
  endtask

  task automatic test_reset_inflight();
    int seen;
    seen = 0;
    @(negedge clk); rd_valid = 1'b1; rd_addr = 3;
    @(posedge clk); #1 rd_valid = 1'b0;
    // A write now leaves the tie-break pointing at read before reset.
    @(negedge clk); wr_valid = 1'b1; wr_addr = 30; wr_data = 8'h99;
    @(posedge clk); #1 wr_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_assert++;
    if ({wr_err, rsp_valid, rsp_err, mem_write, rsp_data, mem_write_address, mem_data_in,
         mem_read_address, wr_count, rd_count} !== '0) begin
      n_fail++; $display("FAIL rst_inflight_outputs nonzero: rv=%b we=%b wa=%0d ra=%0d", rsp_valid, mem_write, mem_write_address, mem_read_address);
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1 if (rsp_valid) seen++; end
    n_assert++;
    if (seen !== 0) begin n_fail++; $display("FAIL rst_inflight_rsp got %0d responses want 0", seen); end
    @(negedge clk); wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 40; wr_data = 8'h01; rd_addr = 41; #1;
    n_assert++;
    if ({wr_ready, rd_ready} !== 2'b10) begin n_fail++; $display("FAIL rst_prio got w%b r%b want w1 r0", wr_ready, rd_ready); end
    @(posedge clk); #1 wr_valid = 1'b0; rd_valid = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 0; i < 14; i++) do_write(10'(100 + i), 8'(i));
    n_assert++;
    if (wr_count !== 4'd14) begin n_fail++; $display("FAIL sat_14 got %0d want 14", wr_count); end
    do_write(114, 8'h0E);
    n_assert++;
    if (wr_count !== 4'd15) begin n_fail++; $display("FAIL sat_15 got %0d want 15", wr_count); end
    for (int i = 0; i < 5; i++) do_write(10'(115 + i), 8'(i));
    n_assert++;
    if (wr_count !== 4'd15) begin n_fail++; $display("FAIL sat_hold got %0d want 15", wr_count); end
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    test_reset();
    test_basic();
    test_round_robin();
    test_range();
    test_back_to_back();
    test_reset_inflight();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
